// File: rtl/core_boot_pkg.sv
// Shared definitions for the RV32 boot sequencer: FSM states, image magic and error codes.
package core_boot_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_MAGIC,
        ST_WAIT_LEN,
        ST_LOAD,
        ST_CHECK,
        ST_RELEASE,
        ST_START,
        ST_RUN,
        ST_ERROR
    } boot_state_t;

    localparam logic [31:0] MAGIC_DEFAULT = 32'h52563332;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_SUM  = 2'b10;

    // States in which the sequencer is consuming the image stream.
    function automatic logic accepts_stream(input boot_state_t s);
        return (s == ST_WAIT_MAGIC) || (s == ST_WAIT_LEN) ||
               (s == ST_LOAD)       || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/core_boot_ctrl.sv
// Boot sequencer: receives an image stream, writes it to instruction memory,
// verifies its checksum, then releases the core from reset and pulses start.
module core_boot_ctrl
    import core_boot_pkg::*;
#(
    parameter int          IMEM_AW = 10,
    parameter logic [31:0] MAGIC   = MAGIC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [31:0]        s_data,
    output logic               s_ready,
    input  logic               reload,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               core_rstn,
    output logic               core_start,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);

    localparam logic [31:0] DEPTH = 32'(2 ** IMEM_AW);

    boot_state_t        state;
    logic [IMEM_AW-1:0] addr;
    logic [IMEM_AW:0]   remaining;
    logic [31:0]        sum;
    logic               xfer;

    assign s_ready = !rst && !reload && accepts_stream(state);
    assign busy    = !rst && accepts_stream(state);
    assign xfer    = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_WAIT_MAGIC;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_rstn  <= 1'b0;
            core_start <= 1'b0;
            done       <= 1'b0;
            err        <= ERR_NONE;
            addr       <= '0;
            remaining  <= '0;
            sum        <= '0;
        end else begin
            imem_we    <= 1'b0;
            core_start <= 1'b0;
            if (reload) begin
                state     <= ST_WAIT_MAGIC;
                err       <= ERR_NONE;
                done      <= 1'b0;
                core_rstn <= 1'b0;
                addr      <= '0;
                remaining <= '0;
                sum       <= '0;
            end else begin
                case (state)
                    ST_WAIT_MAGIC: begin
                        if (xfer && s_data == MAGIC)
                            state <= ST_WAIT_LEN;
                    end
                    ST_WAIT_LEN: begin
                        if (xfer) begin
                            if (s_data == 32'd0 || s_data > DEPTH) begin
                                state <= ST_ERROR;
                                err   <= ERR_LEN;
                            end else begin
                                remaining <= s_data[IMEM_AW:0];
                                addr      <= '0;
                                sum       <= '0;
                                state     <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (xfer) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= addr;
                            imem_wdata <= s_data;
                            // Wraps only after the final legal word, when it is no longer used.
                            addr       <= addr + 1'b1;
                            sum        <= sum + s_data;
                            remaining  <= remaining - 1'b1;
                            if (remaining == (IMEM_AW + 1)'(1))
                                state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (xfer) begin
                            if (s_data == sum) begin
                                state     <= ST_RELEASE;
                                core_rstn <= 1'b1;
                            end else begin
                                state <= ST_ERROR;
                                err   <= ERR_SUM;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        state      <= ST_START;
                        core_start <= 1'b1;
                    end
                    ST_START: begin
                        state <= ST_RUN;
                        done  <= 1'b1;
                    end
                    ST_RUN:   state <= ST_RUN;
                    ST_ERROR: state <= ST_ERROR;
                    default:  state <= ST_WAIT_MAGIC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Self-checking bench for core_boot_ctrl: directed boot scenarios plus randomized
// images, checked against an image-level reference model and a shadow memory.
module tb_core_boot_ctrl;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] MAGIC = 32'h52563332;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_rstn;
    logic          core_start;
    logic          busy;
    logic          done;
    logic [1:0]    err;

    core_boot_ctrl #(.IMEM_AW(AW), .MAGIC(MAGIC)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rstn  (core_rstn),
        .core_start (core_start),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Shadow of instruction memory, filled from the DUT write port.
    logic [31:0] mem_model [DEPTH];
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (imem_we) begin
            mem_model[imem_waddr] <= imem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of an image: 1 bad length, 2 checksum mismatch, 0 boot.
    function automatic logic [1:0] model_err(input logic [31:0] n, input logic [31:0] pay[$],
                                             input logic [31:0] chk);
        logic [31:0] s;
        if (n == 0 || n > 32'(DEPTH)) return 2'd1;
        s = 0;
        foreach (pay[i]) s = s + pay[i];
        return (s == chk) ? 2'd0 : 2'd2;
    endfunction

    // Offer one word after `gap` idle cycles; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] d, input int gap);
        bit ok;
        int i;
        ok = 0;
        repeat (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        i = 0;
        while (!ok && i < 50) begin
            #1;
            if (s_ready) begin
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
            end
            i++;
        end
        #1;
        s_valid = 1'b0;
        check("handshake", 32'(ok), 32'd1);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check("reload_err", 32'(err), 32'd0);
        check("reload_done", 32'(done), 32'd0);
        check("reload_rstn", 32'(core_rstn), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
    endtask

    task automatic run_image(input logic [31:0] n, input logic [31:0] pay[$],
                             input logic [31:0] chk, input int mingap, input int maxgap);
        logic [1:0] exp_err;
        int         base;
        int         mism;
        bit         saw_start;
        bit         saw_rstn;
        exp_err = model_err(n, pay, chk);
        base    = wr_cnt;
        send(MAGIC, 0);
        send(n, $urandom_range(maxgap, mingap));
        if (exp_err == 2'd1) begin
            check("len_err", 32'(err), 32'd1);
            check("len_rstn", 32'(core_rstn), 32'd0);
            check("len_ready", 32'(s_ready), 32'd0);
            check("len_busy", 32'(busy), 32'd0);
            return;
        end
        foreach (pay[i]) begin
            send(pay[i], $urandom_range(maxgap, mingap));
            check("we_latency", 32'(imem_we), 32'd1);
            check("waddr", 32'(imem_waddr), 32'(i));
            check("wdata", imem_wdata, pay[i]);
        end
        send(chk, $urandom_range(maxgap, mingap));
        if (exp_err == 2'd2) begin
            check("sum_err", 32'(err), 32'd2);
            saw_start = 0;
            saw_rstn  = 0;
            repeat (4) begin
                saw_start |= core_start;
                saw_rstn  |= core_rstn;
                @(posedge clk);
                #1;
            end
            check("sum_no_start", 32'(saw_start), 32'd0);
            check("sum_rstn_low", 32'(saw_rstn), 32'd0);
            check("sum_ready", 32'(s_ready), 32'd0);
        end else begin
            check("rel_rstn", 32'(core_rstn), 32'd1);
            check("rel_start", 32'(core_start), 32'd0);
            check("rel_done", 32'(done), 32'd0);
            @(posedge clk);
            #1;
            check("start_pulse", 32'(core_start), 32'd1);
            @(posedge clk);
            #1;
            check("run_start", 32'(core_start), 32'd0);
            check("run_done", 32'(done), 32'd1);
            check("run_rstn", 32'(core_rstn), 32'd1);
            check("run_busy", 32'(busy), 32'd0);
            check("run_ready", 32'(s_ready), 32'd0);
        end
        mism = 0;
        foreach (pay[i]) if (mem_model[i] !== pay[i]) mism++;
        check("write_count", 32'(wr_cnt - base), n);
        check("mem_contents", 32'(mism), 32'd0);
    endtask

    initial begin
        logic [31:0] pay[$];
        logic [31:0] s;
        logic [31:0] v;
        int          base;
        int          n;

        rst = 1'b1; s_valid = 1'b1; s_data = MAGIC; reload = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_rstn", 32'(core_rstn), 32'd0);
        check("rst_start", 32'(core_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        #1;
        check("idle_ready", 32'(s_ready), 32'd1);

        // Basic three-word image, back-to-back.
        pay = '{32'h11, 32'h22, 32'h33};
        run_image(3, pay, 32'h66, 0, 0);
        do_reload();

        // Garbage ahead of the magic word is discarded.
        send(32'hDEADBEEF, 0);
        send(32'h0, 0);
        check("resync_busy", 32'(busy), 32'd1);
        pay = '{32'h5};
        run_image(1, pay, 32'h5, 0, 0);
        do_reload();

        // Length limits.
        pay = {};
        run_image(0, pay, 0, 0, 0);
        do_reload();
        run_image(32'(DEPTH + 1), pay, 0, 0, 0);
        do_reload();

        // Checksum mismatch.
        pay = '{32'h1, 32'h2};
        run_image(2, pay, 32'h4, 0, 0);
        do_reload();

        // Reload mid-payload with a word offered in the same cycle.
        base = wr_cnt;
        send(MAGIC, 0);
        send(4, 0);
        send(32'hA1, 0);
        send(32'hA2, 0);
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'hA3; reload = 1'b1;
        #1;
        check("reload_blocks_ready", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        reload = 1'b0; s_valid = 1'b0;
        check("reload_to_magic", 32'(busy), 32'd1);
        check("reload_err_clr", 32'(err), 32'd0);
        check("pending_write", 32'(wr_cnt - base), 32'd2);
        pay = '{32'hB0, 32'hB1, 32'hB2};
        run_image(3, pay, 32'h213, 0, 1);
        do_reload();

        // Reset in the middle of a load.
        send(MAGIC, 0);
        send(5, 0);
        send(32'hC0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(s_ready), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized images, some with corrupted checksums or bad lengths.
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(2, 0)) begin
                v = $urandom;
                if (v == MAGIC) v = ~v;
                send(v, $urandom_range(1, 0));
            end
            n = (r == 5) ? 0 : int'($urandom_range(24, 1));
            pay = {};
            s = 0;
            for (int i = 0; i < n; i++) begin
                v = $urandom;
                pay.push_back(v);
                s = s + v;
            end
            if ($urandom_range(3, 0) == 0) s = s ^ 32'h1;
            run_image(32'(n), pay, s, 0, 2);
            do_reload();
        end

        // Full-depth image, valid every other cycle, checksum wraps.
        pay = {};
        s = 0;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom | 32'h8000_0000;
            pay.push_back(v);
            s = s + v;
        end
        run_image(32'(DEPTH), pay, s, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
